// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default timing and sizing helpers for the SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Default geometry and timing, shared by the top level and the bench
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_ACCESS_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter width: enough to hold the longest phase length
  function automatic int cnt_width(input int s, input int a, input int h);
    return $clog2(max3(s, a, h) + 1);
  endfunction

endpackage

// File: rtl/sram_io_buf.sv
// Tristate buffer for the SRAM data bus; the only place the inout is driven.
module sram_io_buf #(
  parameter int DATA_W = 4
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  logic [DATA_W-1:0] sram_dq
);

  assign sram_dq = drive_en ? dout : {DATA_W{1'bz}};
  assign din     = sram_dq;

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single requests over valid/ready, sequenced
// CE_n/WE_n/OE_n with programmable setup/access/hold, registered pins.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              MasterClock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  inout  logic [DATA_W-1:0] sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = cnt_width(SETUP_CYC, ACCESS_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ready_q, ready_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                drv_q, drv_d;
  logic [DATA_W-1:0]   din;
  logic                last;

  sram_io_buf #(
    .DATA_W(DATA_W)
  ) u_io (
    .drive_en(drv_q),
    .dout    (wdata_q),
    .din     (din),
    .sram_dq (sram_dq)
  );

  // Next-state, phase counter and next pin values; pins are decoded from the
  // next state so every pin leaves a flop in the same cycle as the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    last        = (cnt_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
          op_write_d = req_write;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
        end
      end
      ST_SETUP: begin
        if (last) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (last) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          // OE_n is still low during this cycle, so the bus carries SRAM data
          if (!op_write_q) begin
            rdata_d = din;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (last) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ce_n_d  = (state_d == ST_IDLE);
    we_n_d  = !((state_d == ST_ACCESS) && op_write_d);
    oe_n_d  = !((state_d == ST_ACCESS) && !op_write_d);
    drv_d   = (state_d != ST_IDLE) && op_write_d;
    ready_d = (state_d == ST_IDLE);
  end

  // State, counter, latched request and registered pin/response flops
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      drv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      drv_q       <= drv_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;

  // Bus-safety invariants on the registered pins
  a_no_contention: assert property (@(posedge MasterClock) disable iff (Reset)
    !(drv_q && !oe_n_q));
  a_strobe_excl: assert property (@(posedge MasterClock) disable iff (Reset)
    !(!we_n_q && !oe_n_q));
  a_ce_with_strobe: assert property (@(posedge MasterClock) disable iff (Reset)
    ce_n_q |-> (we_n_q && oe_n_q && !drv_q));

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: async SRAM models, a transaction-level
// timing model for the default instance, table vectors, random traffic, and
// a second instance with stretched timing and wider buses.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int S   = DEF_SETUP_CYC;
  localparam int A   = DEF_ACCESS_CYC;
  localparam int H   = DEF_HOLD_CYC;
  localparam int TOT = S + A + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- default instance ----------------
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata, sram_addr;
  wire  [3:0] sram_dq;
  logic       sram_ce_n, sram_we_n, sram_oe_n;

  sram_ctrl #(
    .DATA_W(4), .ADDR_W(4), .SETUP_CYC(S), .ACCESS_CYC(A), .HOLD_CYC(H)
  ) u_dut (
    .MasterClock(clk), .Reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_dq(sram_dq), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // Behavioural async SRAM 16x4: drives on CE&OE, writes on WE_n rising
  logic [3:0] sram_mem [16];
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 4'bz;
  always @(posedge sram_we_n) if (!sram_ce_n) sram_mem[sram_addr] = sram_dq;

  // ---------------- stretched instance ----------------
  localparam int S2 = 2, A2 = 3, H2 = 2;
  logic       rst2;
  logic       r2_valid, r2_ready, r2_write;
  logic [9:0] r2_addr, s2_addr;
  logic [7:0] r2_wdata, r2_rdata;
  logic       r2_rsp;
  wire  [7:0] s2_dq;
  logic       s2_ce_n, s2_we_n, s2_oe_n;

  sram_ctrl #(
    .DATA_W(8), .ADDR_W(10), .SETUP_CYC(S2), .ACCESS_CYC(A2), .HOLD_CYC(H2)
  ) u_dut2 (
    .MasterClock(clk), .Reset(rst2),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_write(r2_write),
    .req_addr(r2_addr), .req_wdata(r2_wdata),
    .rsp_valid(r2_rsp), .rsp_rdata(r2_rdata),
    .sram_dq(s2_dq), .sram_addr(s2_addr),
    .sram_ce_n(s2_ce_n), .sram_we_n(s2_we_n), .sram_oe_n(s2_oe_n)
  );

  logic [7:0] mem2 [1024];
  assign s2_dq = (!s2_ce_n && !s2_oe_n) ? mem2[s2_addr] : 8'bz;
  always @(posedge s2_we_n) if (!s2_ce_n) mem2[s2_addr] = s2_dq;

  // ---------------- reference model (transaction level) ----------------
  // m_j counts cycles since the accepting edge: 1..TOT is the access window,
  // TOT+1 is the response cycle.
  bit         m_active;
  int         m_j;
  bit         m_write;
  logic [3:0] m_addr, m_wdata, exp_addr, last_rdata;
  logic [3:0] ref_mem [16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_active || (m_j == TOT + 1);
  endfunction

  task automatic check_pins();
    bit busy, acc_ph;
    busy   = m_active && (m_j <= TOT);
    acc_ph = busy && (m_j > S) && (m_j <= S + A);
    chk("ce_n",      int'(sram_ce_n), int'(!busy));
    chk("we_n",      int'(sram_we_n), int'(!(acc_ph && m_write)));
    chk("oe_n",      int'(sram_oe_n), int'(!(acc_ph && !m_write)));
    chk("dq_drive",  int'(u_dut.u_io.drive_en), int'(busy && m_write));
    if (busy && m_write) chk("dq_data", int'(sram_dq), int'(m_wdata));
    chk("addr",      int'(sram_addr), int'(exp_addr));
    chk("ready",     int'(req_ready), int'(!busy));
    chk("rsp_valid", int'(rsp_valid), int'(m_active && (m_j == TOT + 1)));
    chk("rsp_rdata", int'(rsp_rdata), int'(last_rdata));
    chk("contention", int'(u_dut.u_io.drive_en && !sram_oe_n), 0);
  endtask

  task automatic tick();
    bit acc;
    acc = req_valid && m_ready() && !rst;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      m_active   = 1'b0;
      m_j        = 0;
      last_rdata = '0;
      exp_addr   = '0;
    end else begin
      if (m_active) begin
        m_j++;
        if (m_j > TOT + 1) m_active = 1'b0;
      end
      if (acc) begin
        m_active = 1'b1;
        m_j      = 1;
        m_write  = req_write;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        exp_addr = req_addr;
        if (req_write) ref_mem[req_addr] = req_wdata;
      end
      // read data becomes visible at the start of HOLD
      if (m_active && !m_write && (m_j == S + A + 1)) last_rdata = ref_mem[m_addr];
    end
    check_pins();
  endtask

  task automatic issue(input bit w, input logic [3:0] a, input logic [3:0] d);
    int n;
    n = 0;
    while (!m_ready() && n < 30) begin tick(); n++; end
    if (!m_ready()) chk("wait_ready", 0, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 4'($urandom); req_wdata = 4'($urandom);
  endtask

  task automatic finish_txn();
    int n;
    n = 0;
    while (!(m_active && (m_j == TOT + 1)) && n < 30) begin tick(); n++; end
    if (n >= 30) chk("wait_rsp", 0, 1);
  endtask

  task automatic t2_txn(input bit w, input logic [9:0] a, input logic [7:0] d,
                        output int lat, output int we_lo, output int oe_lo, output int ce_lo);
    int n;
    chk("p2_ready", int'(r2_ready), 1);
    r2_valid = 1'b1; r2_write = w; r2_addr = a; r2_wdata = d;
    @(posedge clk); #1;
    r2_valid = 1'b0; r2_addr = 10'($urandom); r2_wdata = 8'($urandom);
    we_lo = 0; oe_lo = 0; ce_lo = 0; n = 1;
    while (!r2_rsp && n < 40) begin
      if (!s2_we_n) we_lo++;
      if (!s2_oe_n) oe_lo++;
      if (!s2_ce_n) ce_lo++;
      chk("p2_contention", int'(u_dut2.u_io.drive_en && !s2_oe_n), 0);
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  typedef struct {
    bit         w;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [36];

  initial begin
    int lat, we_lo, oe_lo, ce_lo;
    int n;

    // vector table: fill every address, read back in reverse, then the corners
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 4'(i), 4'(i * 7 + 3), 4'h0};
      tbl[16 + i] = '{1'b0, 4'(15 - i), 4'h0, 4'((15 - i) * 7 + 3)};
    end
    tbl[32] = '{1'b1, 4'hF, 4'h0, 4'h0};
    tbl[33] = '{1'b1, 4'h0, 4'hF, 4'h0};
    tbl[34] = '{1'b0, 4'hF, 4'h0, 4'h0};
    tbl[35] = '{1'b0, 4'h0, 4'h0, 4'hF};

    rst = 1'b1; rst2 = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    r2_valid = 1'b0; r2_write = 1'b0; r2_addr = '0; r2_wdata = '0;
    m_active = 1'b0; m_j = 0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; exp_addr = '0; last_rdata = '0;

    // 1: reset then idle
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 2: write 3 <- A
    issue(1'b1, 4'h3, 4'hA);
    finish_txn();
    tick();
    chk("t2_mem3", int'(sram_mem[3]), 'hA);

    // 3: read 3
    issue(1'b0, 4'h3, 4'h0);
    finish_txn();
    chk("t3_rsp", int'(rsp_valid), 1);
    chk("t3_rdata", int'(rsp_rdata), 'hA);

    // 4: back-to-back, write accepted in the read's response cycle
    issue(1'b1, 4'h0, 4'h1);
    finish_txn();
    issue(1'b0, 4'h3, 4'h0);
    finish_txn();
    issue(1'b1, 4'h5, 4'h6);
    finish_txn();
    tick();
    chk("t4_mem5", int'(sram_mem[5]), 'h6);

    // 5: reset during ACCESS of a write, then read addr 0
    issue(1'b1, 4'h9, 4'hE);
    n = 0;
    while (m_j != S + 1 && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    chk("t5_state", int'(u_dut.state_q), int'(ST_IDLE));
    rst = 1'b0;
    issue(1'b0, 4'h0, 4'h0);
    finish_txn();
    chk("t5_rdata", int'(rsp_rdata), 'h1);

    // table vectors
    foreach (tbl[i]) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d);
      finish_txn();
      if (!tbl[i].w) chk("tbl_rd", int'(rsp_rdata), int'(tbl[i].exp));
    end

    // random traffic, inputs churn even while not ready
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom);
      req_addr  = 4'($urandom);
      req_wdata = 4'($urandom);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 6: stretched timing, wide buses
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(posedge clk); #1;
    t2_txn(1'b1, 10'h3FF, 8'hC5, lat, we_lo, oe_lo, ce_lo);
    chk("p2_wr_lat", lat, 1 + S2 + A2 + H2);
    chk("p2_wr_we", we_lo, A2);
    chk("p2_wr_oe", oe_lo, 0);
    chk("p2_wr_ce", ce_lo, S2 + A2 + H2);
    chk("p2_mem", int'(mem2[10'h3FF]), 'hC5);
    t2_txn(1'b0, 10'h3FF, 8'h00, lat, we_lo, oe_lo, ce_lo);
    chk("p2_rd_lat", lat, 1 + S2 + A2 + H2);
    chk("p2_rd_we", we_lo, 0);
    chk("p2_rd_oe", oe_lo, A2);
    chk("p2_rd_ce", ce_lo, S2 + A2 + H2);
    chk("p2_rdata", int'(r2_rdata), 'hC5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
